// File: rtl/div16sx8u_if.sv
// Handshake and data bundle for the div16sx8u sequential divider.
// The master (requester) drives start/dividend/divisor; the slave (divider)
// returns busy/done and the registered results.
interface div16sx8u_if #(
  parameter int DW = 16,
  parameter int VW = 8
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW:0]   remainder;
  logic          div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/div16sx8u.sv
// div16sx8u: 16-bit signed dividend / 8-bit unsigned divisor, restoring
// shift-subtract, one quotient bit per clock (IDLE -> CALC x DW -> FIX).
// Truncating division by default; define DIV_ROUND_EN to round the result
// half away from zero in the FIX step.
module div16sx8u #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic       clk,
  input  logic       reset,
  div16sx8u_if.slave bus
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] mag_q, mag_d;     // dividend magnitude, becomes |quotient|
  logic [VW-1:0] dvs_q, dvs_d;     // captured divisor
  logic [VW:0]   pr_q, pr_d;       // partial remainder
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_q, neg_d;     // dividend (and quotient) sign
  logic          zero_q, zero_d;   // divisor was zero
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW:0]   rem_q, rem_d;
  logic          dz_q, dz_d;

  logic [VW:0]   trial;
  logic          ge;
  logic [VW:0]   diff;
  logic [DW-1:0] q_abs;
  logic [VW-1:0] r_abs;
  logic          r_neg;

  // Next-state, datapath step and final sign/rounding fix-up.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    mag_d   = mag_q;
    dvs_d   = dvs_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    // Shift the next dividend bit into the partial remainder and try a subtract.
    trial = {pr_q[VW-1:0], mag_q[DW-1]};
    ge    = (trial >= {1'b0, dvs_q});
    diff  = trial - {1'b0, dvs_q};

    // Magnitudes of the final result, optionally rounded half away from zero.
    q_abs = mag_q;
    r_abs = pr_q[VW-1:0];
    r_neg = neg_q;
`ifdef DIV_ROUND_EN
    if ({r_abs, 1'b0} >= {1'b0, dvs_q}) begin
      q_abs = mag_q + 1'b1;
      r_abs = dvs_q - r_abs;
      r_neg = ~neg_q;
    end
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          // -2^(DW-1) negates to itself, which is exactly 2^(DW-1) unsigned.
          mag_d   = bus.dividend[DW-1] ? (~bus.dividend + 1'b1) : bus.dividend;
          dvs_d   = bus.divisor;
          neg_d   = bus.dividend[DW-1];
          zero_d  = (bus.divisor == '0);
          pr_d    = '0;
          cnt_d   = CW'(DW);
          busy_d  = 1'b1;
          state_d = (bus.divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        mag_d = {mag_q[DW-2:0], ge};
        pr_d  = ge ? diff : trial;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        if (zero_q) begin
          quo_d = neg_q ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
          rem_d = '0;
          dz_d  = 1'b1;
        end else begin
          quo_d = neg_q ? (~q_abs + 1'b1) : q_abs;
          rem_d = r_neg ? (~{1'b0, r_abs} + 1'b1) : {1'b0, r_abs};
          dz_d  = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; synchronous reset aborts any division.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q <= IDLE;
      mag_q   <= '0;
      dvs_q   <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      dvs_q   <= dvs_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_div16sx8u.sv
// Directed testbench for div16sx8u: exact products, truncation, extremes,
// divide by zero, held/re-issued start, and mid-operation reset.
module tb_div16sx8u;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edges;
  int   busy_cnt;
  int   done_seen;

  always #5 clk = ~clk;

  div16sx8u_if #(.DW(16), .VW(8)) bus ();

  div16sx8u #(.DW(16), .VW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [15:0] exp_q,
                           input logic [8:0] exp_r, input logic exp_dz);
    check({tag, ".q"},  {16'b0, bus.quotient},  {16'b0, exp_q});
    check({tag, ".r"},  {23'b0, bus.remainder}, {23'b0, exp_r});
    check({tag, ".dz"}, {31'b0, bus.div_zero},  {31'b0, exp_dz});
  endtask

  // Present a request at a negedge, let edge E0 accept it, drop start at the
  // following negedge.
  task automatic start_op(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // Called at the negedge after E0; counts edges until done is seen and
  // the cycles in which busy is high. Bounded at 40 edges.
  task automatic wait_done(input string tag);
    edges    = 0;
    busy_cnt = bus.busy ? 1 : 0;
    while (edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.done) break;
      if (bus.busy) busy_cnt++;
    end
    check({tag, ".done_seen"}, {31'b0, bus.done}, 32'd1);
    check({tag, ".busy_in_done"}, {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.busy", {31'b0, bus.busy}, 32'd0);
    check("rst.done", {31'b0, bus.done}, 32'd0);
    check_res("rst", 16'h0000, 9'h000, 1'b0);
    reset = 1'b0;

    // 85*85 = 7225 -> 85 r 0; latency and busy window.
    start_op(16'd7225, 8'd85);
    wait_done("exact");
    check("exact.latency", edges, 32'd17);
    check("exact.busy_cycles", busy_cnt, 32'd17);
    check_res("exact", 16'd85, 9'd0, 1'b0);

    start_op(16'(-32640), 8'd255);
    wait_done("neg255");
    check_res("neg255", 16'(-128), 9'd0, 1'b0);

    start_op(16'(-32640), 8'd100);
    wait_done("neg100");
    check_res("neg100", 16'(-326), 9'(-40), 1'b0);

    start_op(16'd7, 8'd2);
    wait_done("seven2");
`ifdef DIV_ROUND_EN
    check_res("seven2", 16'd4, 9'(-1), 1'b0);
`else
    check_res("seven2", 16'd3, 9'd1, 1'b0);
`endif

    start_op(16'h8000, 8'd1);
    wait_done("min1");
    check_res("min1", 16'h8000, 9'd0, 1'b0);

    start_op(16'd32767, 8'd255);
    wait_done("max255");
    check_res("max255", 16'd128, 9'd127, 1'b0);

    start_op(16'd0, 8'd200);
    wait_done("zero200");
    check_res("zero200", 16'd0, 9'd0, 1'b0);

    // Divide by zero: done one edge after acceptance.
    start_op(16'd1234, 8'd0);
    wait_done("dz");
    check("dz.latency", edges, 32'd1);
    check_res("dz", 16'h7FFF, 9'd0, 1'b1);

    start_op(16'(-5), 8'd3);
    wait_done("m5by3");
`ifdef DIV_ROUND_EN
    check_res("m5by3", 16'(-2), 9'd1, 1'b0);
`else
    check_res("m5by3", 16'(-1), 9'(-2), 1'b0);
`endif

    // Start held high; inputs change while busy; restart in done cycle.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd7;
    @(negedge clk);
    bus.dividend = 16'(-1000);
    bus.divisor  = 8'd9;
    wait_done("held1");
    check("held1.latency", edges, 32'd17);
`ifdef DIV_ROUND_EN
    check_res("held1", 16'd143, 9'(-1), 1'b0);
`else
    check_res("held1", 16'd142, 9'd6, 1'b0);
`endif
    // start is still high in the done cycle: accepted at the next edge.
    @(negedge clk);
    bus.start = 1'b0;
    check("held2.busy", {31'b0, bus.busy}, 32'd1);
    check("held2.done_low", {31'b0, bus.done}, 32'd0);
`ifdef DIV_ROUND_EN
    check("held2.q_hold", {16'b0, bus.quotient}, 32'd143);
`else
    check("held2.q_hold", {16'b0, bus.quotient}, 32'd142);
`endif
    wait_done("held2");
    check("held2.latency", edges, 32'd17);
    check_res("held2", 16'(-111), 9'(-1), 1'b0);

    // Reset during the 8th CALC cycle aborts without a done pulse.
    start_op(16'd500, 8'd3);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort.busy", {31'b0, bus.busy}, 32'd0);
    check("abort.done", {31'b0, bus.done}, 32'd0);
    check_res("abort", 16'd0, 9'd0, 1'b0);
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("abort.no_done", done_seen, 32'd0);

    start_op(16'd300, 8'd16);
    wait_done("after_abort");
    check("after_abort.latency", edges, 32'd17);
`ifdef DIV_ROUND_EN
    check_res("after_abort", 16'd19, 9'(-4), 1'b0);
`else
    check_res("after_abort", 16'd18, 9'd12, 1'b0);
`endif

    // Results hold after the done pulse.
    @(negedge clk);
    check("hold.done_low", {31'b0, bus.done}, 32'd0);
`ifdef DIV_ROUND_EN
    check("hold.q", {16'b0, bus.quotient}, 32'd19);
`else
    check("hold.q", {16'b0, bus.quotient}, 32'd18);
`endif

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/div16sx8u.md
Name: div16sx8u

Overview:
- Sequential divider: 16-bit signed dividend by 8-bit unsigned divisor; returns a signed quotient and a signed remainder.
- Inverse datapath of the 8u x 8s multiplier. Feeding a multiplier product and one of its operands back in recovers the other operand.
- Restoring shift-subtract, one quotient bit per clock. Start/busy/done handshake.

Parameters:
- DW, 16, dividend and quotient width (two's complement).
- VW, 8, divisor width (unsigned); remainder width is VW+1.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  DW  signed dividend; captured on accepted start.
- divisor  input  VW  unsigned divisor; captured on accepted start.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; results valid from this cycle.
- quotient  output  DW  signed quotient.
- remainder  output  VW+1  signed remainder.
- div_zero  output  1  divisor was 0 for the result currently held.

Behaviour:
- Reset (synchronous, highest priority, any state): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_zero=0. A reset mid-operation aborts the division and produces no done.
- States: IDLE, CALC, FIX.
- IDLE, start=1 at edge E0:
  - capture |dividend| into DW-bit magnitude; -2^(DW-1) maps to 2^(DW-1) unsigned.
  - capture divisor, dividend sign, and the quotient sign (= dividend sign).
  - counter=DW; busy=1.
  - divisor!=0 -> CALC; divisor==0 -> FIX with the zero flag set.
- CALC, each edge:
  - partial remainder (VW+1 bits) = {pr, next MSB of magnitude}.
  - if >= divisor: subtract, shift in quotient bit 1; else shift in 0.
  - counter--; after DW steps -> FIX.
- FIX, one edge:
  - quotient = sign ? -q : q.
  - remainder = dividend sign ? -r : r (truncating division; remainder takes the dividend's sign, |r| < divisor).
  - div_zero=0; done=1 for exactly one cycle; busy=0; -> IDLE.
- Latency: done high in the cycle after edge E0+DW+1 (17 edges for DW=16). Throughput is one division per DW+2 cycles; start may be reasserted in the done cycle.
- Divide by zero: FIX on edge E0+1.
  - quotient = 2^(DW-1)-1 (0x7FFF) if dividend >= 0, else -2^(DW-1) (0x8000).
  - remainder=0; div_zero=1; done pulse.
- start while busy: ignored, no queueing. Inputs may change freely after capture.
- quotient, remainder and div_zero hold between done pulses. done is never high while busy is high.
- No overflow case exists: |q| <= 2^(DW-1) occurs only for divisor=1; -2^(DW-1)/1 = 0x8000 exactly.

Optional Feature:
- Macro: DIV_ROUND_EN
- Defined: FIX applies round-half-away-from-zero. If 2*|r| >= divisor then |q|+=1 and |r| = divisor-|r|, with the remainder sign negated relative to the dividend. quotient*divisor+remainder == dividend still holds. Latency unchanged; the divide-by-zero path is unaffected.
- Undefined: truncating result as described above.

Test Plan:
- Exact product: dividend 7225, divisor 85 (0x55*0x55) -> quotient 85, remainder 0, done 17 edges after start, busy high for the 17 cycles before done.
- Negative exact and truncation: -32640 / 255 -> q -128, r 0. -32640 / 100 -> q -326, r -40. With DIV_ROUND_EN, 7 / 2 -> q 4, r -1 (without it: q 3, r 1).
- Extremes: -32768 / 1 -> q 0x8000, r 0. 32767 / 255 -> q 128, r 127. 0 / 200 -> q 0, r 0.
- Divide by zero: 1234 / 0 -> done one edge after start, q 0x7FFF, r 0, div_zero 1. Next start with -5 / 3 -> q -1, r -2, div_zero 0.
- Handshake: start held high across a full operation -> only one division until done; restart in the done cycle is accepted; inputs changed while busy do not affect the result.
- Reset at the 8th CALC cycle -> all outputs 0 next edge, no done pulse; a new start then completes normally.
